// File: rtl/pe_skew_feeder.sv
// Diagonal input skew stage for the PE systolic tile.
// Lane k delays each accepted vector element by k cycles, then the pipe drains and signals done.
module pe_skew_feeder #(
    parameter int B              = 4,
    parameter int quantized_size = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   v_i,
    output logic                                   ready_o,
    input  logic                                   last_i,
    input  logic [quantized_size-1:0][2*B-1:0]     data_i,
    output logic [quantized_size-1:0][2*B-1:0]     data_o,
    output logic [quantized_size-1:0]              v_o,
    output logic                                   busy_o,
    output logic                                   done_o
);

    localparam int CW = (quantized_size > 1) ? $clog2(quantized_size) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          accept;

    assign ready_o = (state != DRAIN);
    assign accept  = v_i && ready_o;
    assign busy_o  = (state != IDLE);
    assign done_o  = (state == DRAIN) && (cnt == '0);

    // The drain count equals the deepest lane's remaining delay after the last accept.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (last_i) begin
                            state <= DRAIN;
                            cnt   <= CW'(quantized_size - 1);
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < quantized_size; k++) begin : g_lane
        logic [2*B-1:0] stage_d [0:k];
        logic [k:0]     stage_v;

        // Free-running chain; empty slots carry zero so data_o never shows stale values.
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                for (int j = 0; j <= k; j++) begin
                    stage_d[j] <= '0;
                end
                stage_v <= '0;
            end else begin
                stage_d[0] <= accept ? data_i[k] : '0;
                stage_v[0] <= accept;
                for (int j = 1; j <= k; j++) begin
                    stage_d[j] <= stage_d[j-1];
                    stage_v[j] <= stage_v[j-1];
                end
            end
        end

        assign data_o[k] = stage_d[k];
        assign v_o[k]    = stage_v[k];
    end

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Self-checking bench for pe_skew_feeder: an 8-lane and a 1-lane instance against a
// history-based model (lane k after edge e shows whatever was accepted at edge e-k).
module tb_pe_skew_feeder;

    localparam int B  = 4;
    localparam int QS = 8;
    localparam int W  = 2 * B;
    localparam int HN = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_i;

    logic                 v0, last0, ready0, busy0, done0;
    logic [QS-1:0][W-1:0] din0, dout0;
    logic [QS-1:0]        vo0;

    logic                 v1, last1, ready1, busy1, done1;
    logic [0:0][W-1:0]    din1, dout1;
    logic [0:0]           vo1;

    pe_skew_feeder #(.B(B), .quantized_size(QS)) dut0 (
        .clk_i(clk), .reset_i(reset_i), .v_i(v0), .ready_o(ready0), .last_i(last0),
        .data_i(din0), .data_o(dout0), .v_o(vo0), .busy_o(busy0), .done_o(done0)
    );

    pe_skew_feeder #(.B(B), .quantized_size(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .v_i(v1), .ready_o(ready1), .last_i(last1),
        .data_i(din1), .data_o(dout1), .v_o(vo1), .busy_o(busy1), .done_o(done1)
    );

    int                   qs_m [2] = '{QS, 1};
    bit                   hv   [2][HN];
    logic [QS-1:0][W-1:0] hd   [2][HN];
    int                   last_edge [2];
    bit                   open_t    [2];
    int                   e;
    int                   checks;
    int                   errors;

    function automatic bit drain_win(int m, int after_edge);
        return last_edge[m] >= 0 && after_edge >= last_edge[m] &&
               after_edge <= last_edge[m] + qs_m[m] - 1;
    endfunction

    function automatic logic [QS-1:0][W-1:0] vec(input logic [7:0] base);
        logic [QS-1:0][W-1:0] r;
        for (int k = 0; k < QS; k++) r[k] = W'(base + 8'(k));
        return r;
    endfunction

    task automatic clear_model();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < HN; i++) begin
                hv[m][i] = 1'b0;
                hd[m][i] = '0;
            end
            last_edge[m] = -1;
            open_t[m]    = 1'b0;
        end
    endtask

    task automatic check_one(string tag, logic [63:0] obs, logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s edge %0d: got %h want %h", tag, e, obs, expv);
        end
    endtask

    task automatic check_dut(int m);
        logic [QS-1:0][W-1:0] exp_d, obs_d;
        logic [QS-1:0]        exp_v, obs_v;
        logic                 exp_done, exp_busy, exp_ready;
        exp_d = '0;
        exp_v = '0;
        for (int k = 0; k < qs_m[m]; k++) begin
            if (e - k >= 0 && hv[m][e-k]) begin
                exp_v[k] = 1'b1;
                exp_d[k] = hd[m][e-k][k];
            end
        end
        exp_done  = last_edge[m] >= 0 && e == last_edge[m] + qs_m[m] - 1;
        exp_busy  = open_t[m] || drain_win(m, e);
        exp_ready = !drain_win(m, e);
        if (m == 0) begin
            obs_d = dout0;
            obs_v = vo0;
            check_one("dut0 data_o", 64'(obs_d), 64'(exp_d));
            check_one("dut0 v_o",    64'(obs_v), 64'(exp_v));
            check_one("dut0 done_o", 64'(done0), 64'(exp_done));
            check_one("dut0 busy_o", 64'(busy0), 64'(exp_busy));
            check_one("dut0 ready_o",64'(ready0),64'(exp_ready));
        end else begin
            obs_d    = '0;
            obs_v    = '0;
            obs_d[0] = dout1[0];
            obs_v[0] = vo1[0];
            check_one("dut1 data_o", 64'(obs_d), 64'(exp_d));
            check_one("dut1 v_o",    64'(obs_v), 64'(exp_v));
            check_one("dut1 done_o", 64'(done1), 64'(exp_done));
            check_one("dut1 busy_o", 64'(busy1), 64'(exp_busy));
            check_one("dut1 ready_o",64'(ready1),64'(exp_ready));
        end
    endtask

    task automatic model_edge(int m, bit acc, bit la, logic [QS-1:0][W-1:0] da);
        hv[m][e] = acc;
        hd[m][e] = acc ? da : '0;
        if (acc) begin
            if (la) begin
                last_edge[m] = e;
                open_t[m]    = 1'b0;
            end else begin
                open_t[m] = 1'b1;
            end
        end
    endtask

    // One clock: drive inputs, advance one edge, update the model, check both DUTs.
    task automatic step(bit va, bit la, logic [QS-1:0][W-1:0] da,
                        bit vb, bit lb, logic [W-1:0] db);
        bit acc0, acc1;
        logic [QS-1:0][W-1:0] db_vec;
        v0 = va; last0 = la; din0 = da;
        v1 = vb; last1 = lb; din1[0] = db;
        acc0 = va && !drain_win(0, e);
        acc1 = vb && !drain_win(1, e);
        db_vec    = '0;
        db_vec[0] = db;
        @(posedge clk);
        e++;
        model_edge(0, acc0, la, da);
        model_edge(1, acc1, lb, db_vec);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic idle_steps(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_reset_outputs();
        check_one("rst data_o0", 64'(dout0),  64'd0);
        check_one("rst v_o0",    64'(vo0),    64'd0);
        check_one("rst done_o0", 64'(done0),  64'd0);
        check_one("rst busy_o0", 64'(busy0),  64'd0);
        check_one("rst ready_o0",64'(ready0), 64'd1);
        check_one("rst data_o1", 64'(dout1),  64'd0);
        check_one("rst v_o1",    64'(vo1),    64'd0);
        check_one("rst done_o1", 64'(done1),  64'd0);
        check_one("rst ready_o1",64'(ready1), 64'd1);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        e       = -1;
        reset_i = 1'b0;
        v0 = 0; last0 = 0; din0 = '0;
        v1 = 0; last1 = 0; din1 = '0;
        clear_model();
        #12;
        check_reset_outputs();
        reset_i = 1'b1;
        #2;

        // Single vector with last: lane k valid only after edge k, done after edge 7.
        step(1'b1, 1'b1, vec(8'h10), 1'b1, 1'b1, 8'h5A);
        idle_steps(10);

        // Three back-to-back vectors, then upstream keeps offering 8'hFF through drain.
        step(1'b1, 1'b0, vec(8'hA0), 1'b1, 1'b0, 8'hA0);
        step(1'b1, 1'b0, vec(8'hB0), 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, vec(8'hC0), 1'b1, 1'b1, 8'hC0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, {QS{8'hFF}}, 1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, vec(8'h20), 1'b0, 1'b0, 8'h00);
        idle_steps(9);

        // Bubble insertion inside a tile.
        step(1'b1, 1'b0, vec(8'h30), 1'b1, 1'b0, 8'h31);
        idle_steps(2);
        step(1'b1, 1'b1, vec(8'h40), 1'b1, 1'b1, 8'h41);
        idle_steps(10);

        // Asynchronous reset in the middle of a stream.
        step(1'b1, 1'b0, vec(8'h50), 1'b1, 1'b0, 8'h51);
        step(1'b1, 1'b0, vec(8'h60), 1'b0, 1'b0, 8'h00);
        #3;
        reset_i = 1'b0;
        #1;
        check_reset_outputs();
        clear_model();
        @(posedge clk);
        #3;
        reset_i = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        #1;
        check_reset_outputs();
        step(1'b1, 1'b1, vec(8'h10), 1'b1, 1'b1, 8'h77);
        idle_steps(10);

        // Randomized traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                 {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 W'($urandom));
        end
        idle_steps(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_skew_feeder.md
Name: pe_skew_feeder

Overview:
- Input skew stage directly upstream of the PE systolic tile.
- Accepts one full data vector per handshake (quantized_size lanes, 2*B bits each) and staggers it diagonally: lane k is delayed k cycles relative to lane 0. This gives the wavefront timing the DP grid expects.
- Inserts zero bubbles when no vector is accepted.
- After the last vector of a tile, drains the skew pipe and signals completion.

Parameters:
- B, default 4: half element width; each lane element is 2*B bits.
- quantized_size, default 8: number of lanes; must be >= 1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- v_i  input  1  upstream vector valid.
- ready_o  output  1  feeder can accept a vector this cycle.
- last_i  input  1  qualifies the accepted vector as the final vector of a tile.
- data_i  input  [2*B-1:0] x quantized_size  input vector, lane k = data_i[k].
- data_o  output  [2*B-1:0] x quantized_size  skewed lanes to the PE array.
- v_o  output  quantized_size  per-lane valid for data_o.
- busy_o  output  1  state != IDLE.
- done_o  output  1  one-cycle pulse when the last lane of the last vector is on data_o.

Behaviour:
- Accept: a vector is accepted on a rising edge when v_i && ready_o.
- Free-running shift: lane k is a shift chain of k+1 registers (data plus valid bit) and advances every clock, with no stall.
  - Stage 0 of every lane loads data_i[k] with valid=1 on accept.
  - Otherwise stage 0 loads 0 with valid=0.
- Output mapping: data_o[k] and v_o[k] are driven from the final stage of lane k.
  - An element accepted at edge t appears on lane k after edge t+k, i.e. latency k+1 edges.
  - Invalid slots are always 0 on data_o, never stale data.
- ready_o: 1 in IDLE and STREAM, 0 in DRAIN. It is combinational from the state and does not depend on v_i.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE: accept without last_i -> STREAM; accept with last_i -> DRAIN.
  - STREAM: accept with last_i -> DRAIN. Accept without last_i, or no accept (bubble), stays in STREAM.
  - DRAIN: no accepts. The drain counter (width clog2(quantized_size), minimum 1 bit) is loaded with quantized_size-1 on entry and decrements each edge. When the counter is 0, done_o=1 for that cycle, and the next edge returns the FSM to IDLE.
- done_o timing: done_o coincides exactly with v_o[quantized_size-1]=1 carrying the last vector.
  - For quantized_size=1 the counter loads 0, so done_o coincides with lane 0 output one edge after accept.
- Last without a preceding stream: last_i is ignored when no accept occurs (v_i=0 or ready_o=0).
- Back-to-back tiles: a new tile may be accepted in the cycle after done_o (IDLE). Its first vector can overlap nothing, because the pipe is empty by then.
- Reset values (reset_i=0, asynchronous): all lane registers and valid bits 0, state IDLE, counter 0.
  - Resulting outputs: data_o=0, v_o=0, done_o=0, busy_o=0, ready_o=1.
- Reset mid-operation: any in-flight partial wavefront is discarded immediately with no done_o. The first accept after reset release starts a fresh tile.
- Widths: no arithmetic on data; it is passed bit-exact.

Test Plan:
- quantized_size=8, B=4, single vector data_i[k]=8'h10+k with last_i=1, accepted at edge 0:
  - v_o[k]=1 and data_o[k]=8'h10+k only after edge k, zero elsewhere.
  - done_o=1 only after edge 7; busy_o falls after edge 8.
- Three back-to-back vectors (8'hA0+k, 8'hB0+k, 8'hC0+k, last on the third):
  - Lane 3 shows A3, B3, C3 after edges 3, 4, 5.
  - ready_o=0 after edge 2 until IDLE.
  - done_o after edge 9.
- Bubble insertion: accept, v_i=0 for 2 cycles, accept with last_i:
  - Lane 5 shows data, 0 (v_o=0), 0 (v_o=0), data after edges 5–8.
- Upstream holds v_i=1 during DRAIN with data 8'hFF:
  - No accept occurs; 8'hFF never appears on data_o.
  - The vector is accepted on the first IDLE cycle.
- Assert reset_i=0 asynchronously mid-STREAM (between edges):
  - data_o and v_o go to 0 immediately; no done_o.
  - ready_o=1 after release; the next tile behaves as in scenario 1.
- quantized_size=1: accept with last_i -> data_o[0] valid and done_o=1 in the same cycle after one edge.
